// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder and its bench.
// Contents:
//   state_t   - controller states (idle, busy, done)
//   cnt_width - width of the slice counter, at least one bit
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_digit.sv
// Combinational DIGIT-bit ripple of full-adder cells.
// Ports:
//   a, b  - operand slices
//   cin   - carry into the LSB cell
//   s     - slice sum
//   cout  - carry out of the MSB cell
//   cmsb  - carry into the MSB cell (used for signed overflow)
module adder_digit #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    always_comb begin
        logic [DIGIT:0] c;
        c    = '0;
        c[0] = cin;
        s    = '0;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[DIGIT];
        cmsb = c[DIGIT-1];
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB slice first.
// Ports:
//   Clock, Reset        - rising-edge clock, asynchronous active-high reset
//   Start               - begin an operation (taken when Ready=1)
//   A, B                - operands
//   CarryIn             - carry into bit 0 (add mode only)
//   Subtract            - 0: A+B+CarryIn, 1: A-B
//   Ready               - Start will be accepted
//   Sum, CarryOut,
//   Overflow            - result, final carry, signed overflow (valid while Done=1)
//   Done                - result valid
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CarryIn,
    input  logic             Subtract,
    output logic             Ready,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Done
);

    localparam int unsigned NSLICE = WIDTH / DIGIT;
    localparam int unsigned CW     = cnt_width(NSLICE);
    localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    logic [DIGIT-1:0]       dig_s;
    logic                   dig_cout;
    logic                   dig_cmsb;
    logic [WIDTH+DIGIT-1:0] sum_cat;

    // Operands shift right each busy cycle, so the active slice is always the low DIGIT bits.
    adder_digit #(
        .DIGIT (DIGIT)
    ) u_adder_digit (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .s    (dig_s),
        .cout (dig_cout),
        .cmsb (dig_cmsb)
    );

    // New slice enters at the top of the sum; after NSLICE cycles slice 0 sits at the bottom.
    assign sum_cat = {dig_s, sum_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;
        ov_d    = ov_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    state_d = StBusy;
                    a_d     = A;
                    // Subtraction is A + ~B + 1; CarryIn is ignored in that mode.
                    b_d     = Subtract ? ~B : B;
                    carry_d = Subtract | CarryIn;
                    cnt_d   = '0;
                end
            end
            StBusy: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                sum_d   = sum_cat[WIDTH+DIGIT-1:DIGIT];
                carry_d = dig_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = StDone;
                    co_d    = dig_cout;
                    ov_d    = dig_cmsb ^ dig_cout;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign Ready    = (state_q != StBusy);
    assign Done     = (state_q == StDone);
    assign Sum      = sum_q;
    assign CarryOut = co_q;
    assign Overflow = ov_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder at WIDTH=8 with DIGIT=1, 2 and 8 side by side.
// Index 0: DIGIT=1 (8 cycles), index 1: DIGIT=2 (4 cycles), index 2: DIGIT=8 (1 cycle).
module tb_digit_serial_adder;
    import digit_serial_adder_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       CarryIn = 1'b0;
    logic       Subtract = 1'b0;
    logic [2:0] start = '0;
    logic [2:0] ready;
    logic [2:0] co;
    logic [2:0] ov;
    logic [2:0] done;
    logic [7:0] sum [3];

    int compared   = 0;
    int mismatched = 0;

    always #5 Clock = ~Clock;

    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .Clock(Clock), .Reset(Reset), .Start(start[0]), .A(A), .B(B), .CarryIn(CarryIn),
        .Subtract(Subtract), .Ready(ready[0]), .Sum(sum[0]), .CarryOut(co[0]),
        .Overflow(ov[0]), .Done(done[0])
    );
    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .Clock(Clock), .Reset(Reset), .Start(start[1]), .A(A), .B(B), .CarryIn(CarryIn),
        .Subtract(Subtract), .Ready(ready[1]), .Sum(sum[1]), .CarryOut(co[1]),
        .Overflow(ov[1]), .Done(done[1])
    );
    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .Clock(Clock), .Reset(Reset), .Start(start[2]), .A(A), .B(B), .CarryIn(CarryIn),
        .Subtract(Subtract), .Ready(ready[2]), .Sum(sum[2]), .CarryOut(co[2]),
        .Overflow(ov[2]), .Done(done[2])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 8 : (d == 1) ? 4 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s A=%02h B=%02h sub=%0b observed=%0h expected=%0h",
                   tag, A, B, Subtract, obs, exp);
        end
    endtask

    // Launch one op on all three instances and check Done timing and results at exact latency.
    task automatic run_all(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic sub);
        logic [7:0] bb;
        logic [8:0] r;
        logic       exp_ov;
        bb     = sub ? ~b : b;
        r      = {1'b0, a} + {1'b0, bb} + 9'(sub | cin);
        exp_ov = (a[7] == bb[7]) && (r[7] != a[7]);
        chk("ready_before", 32'(ready), 32'h7);
        A = a; B = b; CarryIn = cin; Subtract = sub;
        start = 3'b111;
        @(posedge Clock); #1;
        start = 3'b000;
        chk("done_fall", 32'(done), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge Clock); #1;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("done_d%0d_k%0d", d, k), 32'(done[d]), 32'(k >= lat_of(d)));
                if (k == lat_of(d)) begin
                    chk($sformatf("sum_d%0d", d), 32'(sum[d]), 32'(r[7:0]));
                    chk($sformatf("co_d%0d", d), 32'(co[d]), 32'(r[8]));
                    chk($sformatf("ov_d%0d", d), 32'(ov[d]), 32'(exp_ov));
                end
            end
        end
    endtask

    // Single-instance launch on the DIGIT=2 unit; leaves time at accept edge + 1.
    task automatic go2(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub);
        A = a; B = b; CarryIn = cin; Subtract = sub;
        start[1] = 1'b1;
        @(posedge Clock); #1;
        start[1] = 1'b0;
    endtask

    logic [7:0] vals [12];

    initial begin
        vals = '{8'h00, 8'h01, 8'h02, 8'h7E, 8'h7F, 8'h80,
                 8'h81, 8'h55, 8'hAA, 8'hC3, 8'hFE, 8'hFF};

        // Reset state
        #2;
        chk("rst_ready", 32'(ready), 32'h7);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_co", 32'(co), 32'h0);
        chk("rst_ov", 32'(ov), 32'h0);
        for (int d = 0; d < 3; d++) chk($sformatf("rst_sum_d%0d", d), 32'(sum[d]), 32'h0);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock); #1;

        // Hand-computed cases (values held in DONE afterwards)
        run_all(8'hFF, 8'h01, 1'b0, 1'b0);
        chk("h1_sum", 32'(sum[1]), 32'h00);
        chk("h1_co", 32'(co[1]), 32'h1);
        chk("h1_ov", 32'(ov[1]), 32'h0);
        run_all(8'h7F, 8'h01, 1'b0, 1'b0);
        chk("h2_sum", 32'(sum[1]), 32'h80);
        chk("h2_co", 32'(co[1]), 32'h0);
        chk("h2_ov", 32'(ov[1]), 32'h1);
        run_all(8'h05, 8'h07, 1'b1, 1'b1);
        chk("h3_sum", 32'(sum[1]), 32'hFE);
        chk("h3_co", 32'(co[1]), 32'h0);
        chk("h3_ov", 32'(ov[1]), 32'h0);

        // Start during BUSY is ignored; Start in DONE is back-to-back
        go2(8'h12, 8'h34, 1'b0, 1'b0);
        chk("b2b_accept", 32'(done[1]), 32'h0);
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        go2(8'hAA, 8'h55, 1'b0, 1'b1);
        chk("busy_ready", 32'(ready[1]), 32'h0);
        chk("busy_done", 32'(done[1]), 32'h0);
        @(posedge Clock); #1;
        chk("first_done", 32'(done[1]), 32'h1);
        chk("first_sum", 32'(sum[1]), 32'h46);
        chk("first_co", 32'(co[1]), 32'h0);
        chk("first_ov", 32'(ov[1]), 32'h0);
        @(posedge Clock); #1;
        chk("hold_sum", 32'(sum[1]), 32'h46);
        chk("hold_done", 32'(done[1]), 32'h1);
        go2(8'hAA, 8'h55, 1'b0, 1'b1);
        chk("b2b_fall", 32'(done[1]), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge Clock); #1;
            chk($sformatf("b2b_busy_k%0d", k), 32'(done[1]), 32'h0);
        end
        @(posedge Clock); #1;
        chk("second_done", 32'(done[1]), 32'h1);
        chk("second_sum", 32'(sum[1]), 32'h55);
        chk("second_co", 32'(co[1]), 32'h1);
        chk("second_ov", 32'(ov[1]), 32'h1);

        // Reset between edges while busy
        go2(8'h3C, 8'h0F, 1'b0, 1'b0);
        @(posedge Clock); #1;
        #3;
        Reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(ready), 32'h7);
        chk("mid_rst_done", 32'(done), 32'h0);
        chk("mid_rst_sum", 32'(sum[1]), 32'h00);
        chk("mid_rst_co", 32'(co), 32'h0);
        chk("mid_rst_ov", 32'(ov), 32'h0);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock); #1;
        run_all(8'h3C, 8'h0F, 1'b0, 1'b0);
        chk("post_rst_sum", 32'(sum[1]), 32'h4B);

        // Sweep of boundary operands across all modes and digit widths
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 12; i++) begin
                for (int j = 0; j < 12; j++) begin
                    run_all(vals[i], vals[j], m == 1, m == 2);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
